alu_div: RTL



---
 rtl/alu_div.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/alu_div.sv
// alu_div: iterative radix-2 restoring divide/remainder unit for RV64M (DIV/DIVU/REM/REMU and W forms).
// Optional macro ALU_DIV_EARLY_OUT_EN lets divide-by-zero and signed overflow skip the iterations.

`ifndef DATA_BITS
`define DATA_BITS 64
`endif
`ifndef ALU_CTRL_BITS
`define ALU_CTRL_BITS 5
`endif

package alu_div_pkg;
  localparam int CW = `ALU_CTRL_BITS;
  typedef logic [CW-1:0] alu_op_t;

  localparam alu_op_t ALU_MUL   = alu_op_t'(2);
  localparam alu_op_t ALU_DIV   = alu_op_t'(16);
  localparam alu_op_t ALU_DIVU  = alu_op_t'(17);
  localparam alu_op_t ALU_REM   = alu_op_t'(18);
  localparam alu_op_t ALU_REMU  = alu_op_t'(19);
  localparam alu_op_t ALU_DIVW  = alu_op_t'(20);
  localparam alu_op_t ALU_DIVUW = alu_op_t'(21);
  localparam alu_op_t ALU_REMW  = alu_op_t'(22);
  localparam alu_op_t ALU_REMUW = alu_op_t'(23);

  typedef struct packed {
    logic div;   // one of the eight divide ops
    logic w;     // 32-bit word form
    logic sgn;   // signed operands
    logic rem;   // return the remainder instead of the quotient
  } div_dec_t;

  function automatic div_dec_t decode(input alu_op_t op);
    div_dec_t d;
    d = '0;
    case (op)
      ALU_DIV:   d = '{1'b1, 1'b0, 1'b1, 1'b0};
      ALU_DIVU:  d = '{1'b1, 1'b0, 1'b0, 1'b0};
      ALU_REM:   d = '{1'b1, 1'b0, 1'b1, 1'b1};
      ALU_REMU:  d = '{1'b1, 1'b0, 1'b0, 1'b1};
      ALU_DIVW:  d = '{1'b1, 1'b1, 1'b1, 1'b0};
      ALU_DIVUW: d = '{1'b1, 1'b1, 1'b0, 1'b0};
      ALU_REMW:  d = '{1'b1, 1'b1, 1'b1, 1'b1};
      ALU_REMUW: d = '{1'b1, 1'b1, 1'b0, 1'b1};
      default:   d = '0;
    endcase
    return d;
  endfunction
endpackage

module alu_div
  import alu_div_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      Start,
  input  logic [`DATA_BITS-1:0]     A,
  input  logic [`DATA_BITS-1:0]     B,
  input  logic [`ALU_CTRL_BITS-1:0] ALUOp,
  output logic                      Busy,
  output logic                      Done,
  output logic [`DATA_BITS-1:0]     Result
);
  localparam int DW = `DATA_BITS;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           state, state_n;
  div_dec_t         dec_q;
  logic             neg_q, neg_r, zero_q, ovf_q;
  logic [DW-1:0]    dvd_q, dvs_q, rem_q, quo_q;
  logic [5:0]       cnt_q;

  // Operand preparation from the raw inputs, used only on an accepted Start.
  div_dec_t         dec_in;
  logic [DW-1:0]    a_ext, b_ext, a_mag, b_mag, quo_init;
  logic             sa, sb, zero_in, ovf_in, bypass, accept;

  always_comb begin
    dec_in = decode(ALUOp);
    if (dec_in.w) begin
      a_ext = dec_in.sgn ? {{32{A[31]}}, A[31:0]} : {32'b0, A[31:0]};
      b_ext = dec_in.sgn ? {{32{B[31]}}, B[31:0]} : {32'b0, B[31:0]};
    end else begin
      a_ext = A;
      b_ext = B;
    end
    sa       = dec_in.sgn & a_ext[DW-1];
    sb       = dec_in.sgn & b_ext[DW-1];
    a_mag    = sa ? -a_ext : a_ext;
    b_mag    = sb ? -b_ext : b_ext;
    // W ops run 32 iterations, so the dividend starts in the upper half.
    quo_init = dec_in.w ? {a_mag[31:0], 32'b0} : a_mag;
    zero_in  = (b_ext == '0);
    ovf_in   = dec_in.sgn && (dec_in.w ? (A[31:0] == 32'h8000_0000 && B[31:0] == 32'hFFFF_FFFF)
                                       : (A == {1'b1, {(DW-1){1'b0}}} && B == '1));
`ifdef ALU_DIV_EARLY_OUT_EN
    bypass   = !dec_in.div || zero_in || ovf_in;
`else
    bypass   = !dec_in.div;
`endif
    accept   = (state == S_IDLE) && Start;
  end

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor.
  logic [DW:0]   part;
  logic          no_borrow;
  logic [DW-1:0] rem_step, quo_step;

  always_comb begin
    part      = {rem_q, quo_q[DW-1]};
    no_borrow = (part >= {1'b0, dvs_q});
    rem_step  = no_borrow ? (part[DW-1:0] - dvs_q) : part[DW-1:0];
    quo_step  = {quo_q[DW-2:0], no_borrow};
  end

  // Fix-up: sign correction, special-case override, select, word extension.
  logic [DW-1:0] q_fix, r_fix, sel, fix_result;

  always_comb begin
    q_fix = neg_q ? -quo_q : quo_q;
    r_fix = neg_r ? -rem_q : rem_q;
    // Special cases are final values and must not pass through the sign correction.
    if (zero_q) begin
      q_fix = '1;
      r_fix = dvd_q;
    end else if (ovf_q) begin
      q_fix = dvd_q;
      r_fix = '0;
    end
    sel        = dec_q.rem ? r_fix : q_fix;
    fix_result = dec_q.w ? {{32{sel[31]}}, sel[31:0]} : sel;
    if (!dec_q.div) fix_result = '0;
  end

  // NOTE: every variable assigned in always_comb gets a value on all paths (default first) so no latch is inferred.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (Start) state_n = bypass ? S_FIX : S_CALC;
      S_CALC:  if (cnt_q == '0) state_n = S_FIX;
      S_FIX:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_n;
  end

  // NOTE: the datapath registers are plain flops (not a memory), so clearing them on reset is cheap and keeps restart deterministic.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dec_q  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      dec_q  <= dec_in;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      zero_q <= zero_in;
      ovf_q  <= ovf_in;
      dvd_q  <= a_ext;
      dvs_q  <= b_mag;
      rem_q  <= '0;
      quo_q  <= quo_init;
      cnt_q  <= dec_in.w ? 6'd31 : 6'd63;
    end else if (state == S_CALC) begin
      rem_q  <= rem_step;
      quo_q  <= quo_step;
      cnt_q  <= cnt_q - 6'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Result <= '0;
    end else begin
      Done <= (state == S_FIX);
      if (accept)               Busy <= !bypass;
      else if (state == S_FIX)  Busy <= 1'b0;
      if (state == S_FIX)       Result <= fix_result;
    end
  end
endmodule
